// File: rtl/sram_mb_bank_sched.sv
// Bank scheduler for a multi-bank two-port SRAM: fills and drains whole banks in ring order,
// arbitrating write/read round-robin over the shared bank select.
module sram_mb_bank_sched #(
   parameter int NUMB_BNK    = 2,
   parameter int SIZE        = 64,
   parameter int DATA_WD     = 32,
   parameter int NUMB_BNK_WD = $clog2(NUMB_BNK),
   parameter int SIZE_WD     = $clog2(SIZE)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   clr_i,
   input  logic                   wr_val_i,
   input  logic [DATA_WD-1:0]     wr_dat_i,
   output logic                   wr_rdy_o,
   input  logic                   rd_req_i,
   output logic                   rd_ack_o,
   output logic                   rd_val_o,
   output logic                   rd_lst_o,
   output logic [NUMB_BNK_WD:0]   cnt_ful_o,
   output logic [NUMB_BNK_WD-1:0] sram_idx_bnk_o,
   output logic                   sram_wr_val_o,
   output logic [SIZE_WD-1:0]     sram_wr_adr_o,
   output logic [DATA_WD-1:0]     sram_wr_dat_o,
   output logic                   sram_rd_val_o,
   output logic [SIZE_WD-1:0]     sram_rd_adr_o
);

   localparam logic [NUMB_BNK_WD-1:0] BNK_LST = NUMB_BNK_WD'(NUMB_BNK - 1);
   localparam logic [SIZE_WD-1:0]     ADR_LST = SIZE_WD'(SIZE - 1);

   logic [NUMB_BNK-1:0]    ful_r, ful_nxt;
   logic [NUMB_BNK_WD-1:0] wr_bnk_r, rd_bnk_r, lck_bnk_r, idx_r;
   logic [SIZE_WD-1:0]     wr_adr_r, rd_adr_r;
   logic [NUMB_BNK_WD:0]   cnt_ful_r, cnt_nxt;
   logic                   rr_r, lck_val_r, rd_val_r, rd_lst_r;
   logic                   wr_elg, rd_elg, wr_gnt, rd_gnt, wr_lst, rd_lst;

   assign wr_lst = (wr_adr_r == ADR_LST);
   assign rd_lst = (rd_adr_r == ADR_LST);

   // In the cycle after a read the select must stay on that bank, so only ops on it may issue.
   assign wr_elg = wr_val_i & ~ful_r[wr_bnk_r] & (~lck_val_r | (wr_bnk_r == lck_bnk_r)) & ~clr_i;
   assign rd_elg = rd_req_i &  ful_r[rd_bnk_r] & (~lck_val_r | (rd_bnk_r == lck_bnk_r)) & ~clr_i;
   assign wr_gnt = wr_elg & (~rd_elg | rr_r);
   assign rd_gnt = rd_elg & ~wr_gnt;

   always_comb begin
      ful_nxt = ful_r;
      if (wr_gnt && wr_lst) ful_nxt[wr_bnk_r] = 1'b1;
      if (rd_gnt && rd_lst) ful_nxt[rd_bnk_r] = 1'b0;
      cnt_nxt = '0;
      for (int i = 0; i < NUMB_BNK; i++)
         cnt_nxt = cnt_nxt + {{NUMB_BNK_WD{1'b0}}, ful_nxt[i]};
   end

   always_comb begin
      if (lck_val_r)   sram_idx_bnk_o = lck_bnk_r;
      else if (wr_gnt) sram_idx_bnk_o = wr_bnk_r;
      else if (rd_gnt) sram_idx_bnk_o = rd_bnk_r;
      else             sram_idx_bnk_o = idx_r;
   end

   assign wr_rdy_o      = wr_gnt;
   assign rd_ack_o      = rd_gnt;
   assign sram_wr_val_o = wr_gnt;
   assign sram_wr_adr_o = wr_adr_r;
   assign sram_wr_dat_o = wr_dat_i;
   assign sram_rd_val_o = rd_gnt;
   assign sram_rd_adr_o = rd_adr_r;
   assign rd_val_o      = rd_val_r;
   assign rd_lst_o      = rd_lst_r;
   assign cnt_ful_o     = cnt_ful_r;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ful_r     <= '0;
         wr_bnk_r  <= '0;
         wr_adr_r  <= '0;
         rd_bnk_r  <= '0;
         rd_adr_r  <= '0;
         lck_val_r <= 1'b0;
         lck_bnk_r <= '0;
         idx_r     <= '0;
         cnt_ful_r <= '0;
         rd_val_r  <= 1'b0;
         rd_lst_r  <= 1'b0;
         rr_r      <= 1'b1;
      end else if (clr_i) begin
         ful_r     <= '0;
         wr_bnk_r  <= '0;
         wr_adr_r  <= '0;
         rd_bnk_r  <= '0;
         rd_adr_r  <= '0;
         lck_val_r <= 1'b0;
         lck_bnk_r <= '0;
         idx_r     <= '0;
         cnt_ful_r <= '0;
         rd_val_r  <= 1'b0;
         rd_lst_r  <= 1'b0;
         rr_r      <= 1'b1;
      end else begin
         ful_r     <= ful_nxt;
         cnt_ful_r <= cnt_nxt;
         idx_r     <= sram_idx_bnk_o;
         rd_val_r  <= rd_gnt;
         rd_lst_r  <= rd_gnt & rd_lst;
         lck_val_r <= rd_gnt;
         if (rd_gnt) lck_bnk_r <= rd_bnk_r;
         if (wr_gnt || rd_gnt) rr_r <= rd_gnt;
         if (wr_gnt) begin
            wr_adr_r <= wr_lst ? '0 : wr_adr_r + 1'b1;
            if (wr_lst) wr_bnk_r <= (wr_bnk_r == BNK_LST) ? '0 : wr_bnk_r + 1'b1;
         end
         if (rd_gnt) begin
            rd_adr_r <= rd_lst ? '0 : rd_adr_r + 1'b1;
            if (rd_lst) rd_bnk_r <= (rd_bnk_r == BNK_LST) ? '0 : rd_bnk_r + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sram_mb_bank_sched.sv
// Directed bench for sram_mb_bank_sched (2 banks x 4 words) with a behavioural SRAM whose read
// data is muxed by the current bank select, as in the real macro.
module tb_sram_mb_bank_sched;

   localparam int NB = 2, SZ = 4, DW = 32;

   logic          clk = 1'b0, rstn = 1'b0, clr_i = 1'b0;
   logic          wr_val_i = 1'b0, rd_req_i = 1'b0;
   logic [DW-1:0] wr_dat_i = '0;
   logic          wr_rdy_o, rd_ack_o, rd_val_o, rd_lst_o;
   logic [1:0]    cnt_ful_o;
   logic [0:0]    sram_idx_bnk_o;
   logic          sram_wr_val_o, sram_rd_val_o;
   logic [1:0]    sram_wr_adr_o, sram_rd_adr_o;
   logic [DW-1:0] sram_wr_dat_o;

   int n_chk = 0, n_pass = 0;

   sram_mb_bank_sched #(.NUMB_BNK(NB), .SIZE(SZ), .DATA_WD(DW)) dut (
      .clk(clk), .rstn(rstn), .clr_i(clr_i),
      .wr_val_i(wr_val_i), .wr_dat_i(wr_dat_i), .wr_rdy_o(wr_rdy_o),
      .rd_req_i(rd_req_i), .rd_ack_o(rd_ack_o), .rd_val_o(rd_val_o), .rd_lst_o(rd_lst_o),
      .cnt_ful_o(cnt_ful_o), .sram_idx_bnk_o(sram_idx_bnk_o),
      .sram_wr_val_o(sram_wr_val_o), .sram_wr_adr_o(sram_wr_adr_o), .sram_wr_dat_o(sram_wr_dat_o),
      .sram_rd_val_o(sram_rd_val_o), .sram_rd_adr_o(sram_rd_adr_o)
   );

   always #5 clk = ~clk;

   // SRAM model: synchronous write, read address registered, output muxed by the live select.
   logic [DW-1:0] mem [NB][SZ];
   logic [1:0]    rd_adr_q = '0;
   always @(posedge clk) begin
      if (sram_wr_val_o) mem[sram_idx_bnk_o][sram_wr_adr_o] <= sram_wr_dat_o;
      if (sram_rd_val_o) rd_adr_q <= sram_rd_adr_o;
   end
   wire [DW-1:0] rd_dat = mem[sram_idx_bnk_o][rd_adr_q];

   task automatic step;
      @(posedge clk); #1;
   endtask

   task automatic do_reset;
      clr_i = 1'b0; wr_val_i = 1'b0; rd_req_i = 1'b0;
      #2 rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
   endtask

   task automatic fill(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         wr_val_i = 1'b1; wr_dat_i = base + DW'(i);
         step;
      end
      wr_val_i = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      #1;
      n_chk++; if (cnt_ful_o !== 2'd0) $display("FAIL rst_cnt: got %0d want 0", cnt_ful_o); else n_pass++;
      n_chk++; if (rd_val_o !== 1'b0 || rd_lst_o !== 1'b0) $display("FAIL rst_rdval: got %b%b want 00", rd_val_o, rd_lst_o); else n_pass++;
      n_chk++; if (sram_idx_bnk_o !== 1'b0) $display("FAIL rst_idx: got %0d want 0", sram_idx_bnk_o); else n_pass++;
      n_chk++; if (sram_wr_val_o !== 1'b0 || sram_rd_val_o !== 1'b0 || wr_rdy_o !== 1'b0)
         $display("FAIL rst_vals: got wv=%b rv=%b rdy=%b want 000", sram_wr_val_o, sram_rd_val_o, wr_rdy_o); else n_pass++;
      wr_val_i = 1'b1; rd_req_i = 1'b1; #1;
      n_chk++; if (wr_rdy_o !== 1'b1 || sram_wr_adr_o !== 2'd0) $display("FAIL rst_wrdy: got rdy=%b adr=%0d want 1,0", wr_rdy_o, sram_wr_adr_o); else n_pass++;
      n_chk++; if (rd_ack_o !== 1'b0) $display("FAIL rst_rdack_empty: got %b want 0", rd_ack_o); else n_pass++;
      wr_val_i = 1'b0; rd_req_i = 1'b0;
   endtask

   task automatic test_fill;
      do_reset;
      for (int i = 0; i < 8; i++) begin
         wr_val_i = 1'b1; wr_dat_i = 32'hD000 + DW'(i); #1;
         if (i == 4) begin
            n_chk++; if (cnt_ful_o !== 2'd1) $display("FAIL fill_cnt1: got %0d want 1", cnt_ful_o); else n_pass++;
         end
         n_chk++; if (wr_rdy_o !== 1'b1 || sram_wr_adr_o !== 2'(i % 4) || sram_idx_bnk_o !== 1'(i / 4))
            $display("FAIL fill_w%0d: got rdy=%b bnk=%0d adr=%0d want 1,%0d,%0d", i, wr_rdy_o, sram_idx_bnk_o, sram_wr_adr_o, i / 4, i % 4);
         else n_pass++;
         step;
      end
      n_chk++; if (cnt_ful_o !== 2'd2) $display("FAIL fill_cnt2: got %0d want 2", cnt_ful_o); else n_pass++;
      n_chk++; if (mem[1][3] !== 32'hD007) $display("FAIL fill_mem13: got %0h want d007", mem[1][3]); else n_pass++;
      #1;
      n_chk++; if (wr_rdy_o !== 1'b0) $display("FAIL fill_full_rdy: got %b want 0", wr_rdy_o); else n_pass++;
      wr_val_i = 1'b0;
   endtask

   task automatic test_drain;
      do_reset;
      fill(4, 32'hD000);
      n_chk++; if (cnt_ful_o !== 2'd1) $display("FAIL drain_cnt_pre: got %0d want 1", cnt_ful_o); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         rd_req_i = 1'b1; #1;
         n_chk++; if (rd_ack_o !== (k < 4) || (k < 4 && sram_rd_adr_o !== 2'(k)))
            $display("FAIL drain_ack%0d: got ack=%b adr=%0d want %b,%0d", k, rd_ack_o, sram_rd_adr_o, k < 4, k);
         else n_pass++;
         step;
         n_chk++; if (rd_val_o !== (k < 4) || rd_lst_o !== (k == 3))
            $display("FAIL drain_val%0d: got val=%b lst=%b want %b,%b", k, rd_val_o, rd_lst_o, k < 4, k == 3);
         else n_pass++;
         if (k < 4) begin
            n_chk++; if (rd_dat !== 32'hD000 + DW'(k)) $display("FAIL drain_dat%0d: got %0h want %0h", k, rd_dat, 32'hD000 + k); else n_pass++;
         end
      end
      n_chk++; if (cnt_ful_o !== 2'd0) $display("FAIL drain_cnt_post: got %0d want 0", cnt_ful_o); else n_pass++;
      rd_req_i = 1'b0;
   endtask

   task automatic test_arb;
      bit ew [10], er [10];
      int es [10];
      logic [DW-1:0] exp_q [$];
      int wn = 0;
      ew = '{1,0,0,0,0,1,1,1,0,0};
      er = '{0,1,1,1,0,0,0,0,1,1};
      es = '{1,0,0,0,0,1,1,1,1,1};
      do_reset;
      fill(4, 32'hD000);
      rd_req_i = 1'b1; step;          // read D0: last grant becomes read
      rd_req_i = 1'b0; step;          // lock cycle passes idle
      exp_q = '{32'hD001, 32'hD002, 32'hD003};
      for (int c = 0; c < 10; c++) begin
         wr_val_i = 1'b1; rd_req_i = 1'b1; wr_dat_i = 32'hE000 + DW'(wn); #1;
         n_chk++; if (wr_rdy_o !== ew[c] || rd_ack_o !== er[c] || sram_idx_bnk_o !== 1'(es[c]))
            $display("FAIL arb_c%0d: got w=%b r=%b sel=%0d want %b,%b,%0d", c, wr_rdy_o, rd_ack_o, sram_idx_bnk_o, ew[c], er[c], es[c]);
         else n_pass++;
         if (ew[c]) begin exp_q.push_back(wr_dat_i); wn++; end
         step;
         if (er[c]) begin
            n_chk++; if (rd_val_o !== 1'b1 || rd_dat !== exp_q[0])
               $display("FAIL arb_dat%0d: got val=%b dat=%0h want 1,%0h", c, rd_val_o, rd_dat, exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
         end
      end
      wr_val_i = 1'b0; rd_req_i = 1'b0;
   endtask

   task automatic test_back_to_back;
      bit ea [10];
      ea = '{1,1,1,1,0,1,1,1,1,0};
      do_reset;
      fill(8, 32'hD000);
      for (int c = 0; c < 10; c++) begin
         rd_req_i = 1'b1; wr_val_i = (c == 4); wr_dat_i = 32'hF000; #1;
         n_chk++; if (rd_ack_o !== ea[c] || wr_rdy_o !== (c == 4))
            $display("FAIL b2b_c%0d: got ack=%b rdy=%b want %b,%b", c, rd_ack_o, wr_rdy_o, ea[c], c == 4);
         else n_pass++;
         if (c == 4) begin
            n_chk++; if (sram_idx_bnk_o !== 1'b0 || sram_wr_adr_o !== 2'd0)
               $display("FAIL b2b_freed_wr: got bnk=%0d adr=%0d want 0,0", sram_idx_bnk_o, sram_wr_adr_o);
            else n_pass++;
         end
         step;
         if (ea[c]) begin
            n_chk++; if (rd_dat !== 32'hD000 + DW'(c < 4 ? c : c - 1) || rd_lst_o !== (c == 3 || c == 8))
               $display("FAIL b2b_dat%0d: got dat=%0h lst=%b want %0h,%b", c, rd_dat, rd_lst_o, 32'hD000 + (c < 4 ? c : c - 1), c == 3 || c == 8);
            else n_pass++;
         end
      end
      rd_req_i = 1'b0; wr_val_i = 1'b0;
   endtask

   task automatic test_ring;
      int nw = 0, nr = 0;
      do_reset;
      for (int r = 0; r < 3; r++) begin
         int got = 0, bud = 0;
         while (got < 8 && bud < 40) begin
            bit hs;
            wr_val_i = 1'b1; wr_dat_i = 32'h100 + DW'(nw); #1;
            hs = wr_rdy_o;
            step;
            if (hs) begin nw++; got++; end
            bud++;
         end
         wr_val_i = 1'b0;
         n_chk++; if (got != 8 || cnt_ful_o !== 2'd2) $display("FAIL ring_fill%0d: got %0d words cnt=%0d want 8,2", r, got, cnt_ful_o); else n_pass++;
         got = 0; bud = 0;
         rd_req_i = 1'b1;
         while (got < 8 && bud < 40) begin
            step;
            if (rd_val_o) begin
               n_chk++; if (rd_dat !== 32'h100 + DW'(nr)) $display("FAIL ring_dat%0d: got %0h want %0h", nr, rd_dat, 32'h100 + nr); else n_pass++;
               nr++; got++;
            end
            bud++;
         end
         rd_req_i = 1'b0; step;
         n_chk++; if (got != 8 || rd_val_o !== 1'b0 || cnt_ful_o !== 2'd0)
            $display("FAIL ring_drain%0d: got %0d words val=%b cnt=%0d want 8,0,0", r, got, rd_val_o, cnt_ful_o);
         else n_pass++;
      end
   endtask

   task automatic test_clr;
      do_reset;
      fill(2, 32'hD000);
      clr_i = 1'b1; step; clr_i = 1'b0;
      n_chk++; if (cnt_ful_o !== 2'd0 || rd_val_o !== 1'b0) $display("FAIL clr_state: got cnt=%0d val=%b want 0,0", cnt_ful_o, rd_val_o); else n_pass++;
      wr_val_i = 1'b1; wr_dat_i = 32'hC000; #1;
      n_chk++; if (wr_rdy_o !== 1'b1 || sram_wr_adr_o !== 2'd0 || sram_idx_bnk_o !== 1'b0)
         $display("FAIL clr_wr: got rdy=%b bnk=%0d adr=%0d want 1,0,0", wr_rdy_o, sram_idx_bnk_o, sram_wr_adr_o);
      else n_pass++;
      step;
      fill(3, 32'hC001);
      n_chk++; if (cnt_ful_o !== 2'd1) $display("FAIL clr_refill: got cnt=%0d want 1", cnt_ful_o); else n_pass++;
      rd_req_i = 1'b1; step;
      n_chk++; if (rd_val_o !== 1'b1 || rd_dat !== 32'hC000) $display("FAIL rst_mid_rd0: got val=%b dat=%0h want 1,c000", rd_val_o, rd_dat); else n_pass++;
      #1;
      n_chk++; if (rd_ack_o !== 1'b1) $display("FAIL rst_mid_ack: got %b want 1", rd_ack_o); else n_pass++;
      rstn = 1'b0; #1;
      n_chk++; if (rd_val_o !== 1'b0 || cnt_ful_o !== 2'd0 || rd_ack_o !== 1'b0)
         $display("FAIL rst_async: got val=%b cnt=%0d ack=%b want 0,0,0", rd_val_o, cnt_ful_o, rd_ack_o);
      else n_pass++;
      rstn = 1'b1; rd_req_i = 1'b0; #1;
      step;
      n_chk++; if (rd_val_o !== 1'b0) $display("FAIL rst_post_val: got %b want 0", rd_val_o); else n_pass++;
      wr_val_i = 1'b1; #1;
      n_chk++; if (wr_rdy_o !== 1'b1 || sram_wr_adr_o !== 2'd0 || sram_idx_bnk_o !== 1'b0)
         $display("FAIL rst_post_wr: got rdy=%b bnk=%0d adr=%0d want 1,0,0", wr_rdy_o, sram_idx_bnk_o, sram_wr_adr_o);
      else n_pass++;
      wr_val_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_fill;
      test_drain;
      test_arb;
      test_back_to_back;
      test_ring;
      test_clr;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
